// File: rtl/watchdog_heartbeat_gen_if.sv
// Heartbeat producer <-> watchdog signal bundle; master drives liveness/control, slave returns heartbeat/status.
// Optional miss-injection signals exist only when HB_MISS_INJECT_EN is defined.
interface watchdog_heartbeat_gen_if;
   logic        enable;
   logic        alive;
   logic        force_reset;
   logic        heartbeat;
   logic [15:0] hb_count;
   logic [1:0]  state;
   logic        stalled;
   logic        recovering;
`ifdef HB_MISS_INJECT_EN
   logic        inject_miss;
   logic [7:0]  miss_len;
   logic        inject_active;

   modport master (output enable, alive, force_reset, inject_miss, miss_len,
                   input  heartbeat, hb_count, state, stalled, recovering, inject_active);
   modport slave  (input  enable, alive, force_reset, inject_miss, miss_len,
                   output heartbeat, hb_count, state, stalled, recovering, inject_active);
`else
   modport master (output enable, alive, force_reset,
                   input  heartbeat, hb_count, state, stalled, recovering);
   modport slave  (input  enable, alive, force_reset,
                   output heartbeat, hb_count, state, stalled, recovering);
`endif
endinterface

// File: rtl/watchdog_heartbeat_gen.sv
// Liveness-gated heartbeat generator with watchdog recovery hold-off; all outputs registered, 1-cycle latency, no backpressure.
// HB_MISS_INJECT_EN adds suppression of the next miss_len due heartbeats for watchdog fault testing.
module watchdog_heartbeat_gen #(
   parameter int HB_PERIOD      = 16,
   parameter int ALIVE_WINDOW   = 64,
   parameter int RECOVER_CYCLES = 32,
   parameter int CNT_W          = 32
) (
   input  logic                     clk,
   input  logic                     rstn,
   watchdog_heartbeat_gen_if.slave  hb_if
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_STALL   = 2'd2,
      S_RECOVER = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(HB_PERIOD - 1);
   localparam logic [CNT_W-1:0] ALIVE_LAST  = CNT_W'(ALIVE_WINDOW - 1);
   localparam logic [CNT_W-1:0] REC_LAST    = CNT_W'(RECOVER_CYCLES - 1);

   state_t           r_state;
   logic             r_heartbeat;
   logic             r_stalled;
   logic             r_recovering;
   logic [15:0]      r_hb_count;
   logic [CNT_W-1:0] r_period_cnt;
   logic [CNT_W-1:0] r_alive_cnt;
   logic [CNT_W-1:0] r_rec_cnt;

   logic             w_hb_due;
   logic             w_expire;
   logic             w_suppress;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign w_hb_due = (r_period_cnt == PERIOD_LAST);
   assign w_expire = !hb_if.alive && (r_alive_cnt == ALIVE_LAST);

`ifdef HB_MISS_INJECT_EN
   logic       r_inj_prev;
   logic [7:0] r_miss_left;
   logic       w_inj_load;

   assign w_suppress          = (r_miss_left != 8'd0);
   assign w_inj_load          = hb_if.inject_miss && !r_inj_prev && (hb_if.miss_len != 8'd0);
   assign hb_if.inject_active = w_suppress;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_inj_prev  <= 1'b0;
         r_miss_left <= 8'd0;
      end else begin
         r_inj_prev <= hb_if.inject_miss;
         // Pending suppression only survives while the FSM stays in RUN.
         if (!hb_if.enable || hb_if.force_reset || r_state != S_RUN || w_expire) begin
            r_miss_left <= 8'd0;
         end else if (w_inj_load) begin
            r_miss_left <= hb_if.miss_len;
         end else if (w_hb_due && w_suppress) begin
            r_miss_left <= r_miss_left - 8'd1;
         end
      end
   end
`else
   assign w_suppress = 1'b0;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= S_IDLE;
         r_heartbeat  <= 1'b0;
         r_stalled    <= 1'b0;
         r_recovering <= 1'b0;
         r_hb_count   <= 16'd0;
         r_period_cnt <= '0;
         r_alive_cnt  <= '0;
         r_rec_cnt    <= '0;
      end else begin
         r_heartbeat <= 1'b0;
         if (r_heartbeat) begin
            r_hb_count <= r_hb_count + 16'd1;
         end
         if (!hb_if.enable) begin
            r_state      <= S_IDLE;
            r_stalled    <= 1'b0;
            r_recovering <= 1'b0;
            r_period_cnt <= '0;
            r_alive_cnt  <= '0;
            r_rec_cnt    <= '0;
         end else if (hb_if.force_reset) begin
            // Any force_reset cycle restarts the recovery hold-off.
            r_state      <= S_RECOVER;
            r_stalled    <= 1'b0;
            r_recovering <= 1'b1;
            r_period_cnt <= '0;
            r_alive_cnt  <= '0;
            r_rec_cnt    <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state      <= S_RUN;
                  r_period_cnt <= '0;
                  r_alive_cnt  <= '0;
               end
               S_RUN: begin
                  if (w_expire) begin
                     r_state      <= S_STALL;
                     r_stalled    <= 1'b1;
                     r_period_cnt <= '0;
                     r_alive_cnt  <= '0;
                  end else begin
                     r_alive_cnt <= hb_if.alive ? '0 : sat_inc(r_alive_cnt);
                     if (w_hb_due) begin
                        r_period_cnt <= '0;
                        r_heartbeat  <= !w_suppress;
                     end else begin
                        r_period_cnt <= sat_inc(r_period_cnt);
                     end
                  end
               end
               S_STALL: begin
                  if (hb_if.alive) begin
                     r_state      <= S_RUN;
                     r_stalled    <= 1'b0;
                     r_period_cnt <= '0;
                     r_alive_cnt  <= '0;
                  end
               end
               S_RECOVER: begin
                  if (r_rec_cnt == REC_LAST) begin
                     r_state      <= S_RUN;
                     r_recovering <= 1'b0;
                     r_rec_cnt    <= '0;
                     r_period_cnt <= '0;
                     r_alive_cnt  <= '0;
                  end else begin
                     r_rec_cnt <= sat_inc(r_rec_cnt);
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign hb_if.heartbeat  = r_heartbeat;
   assign hb_if.hb_count   = r_hb_count;
   assign hb_if.state      = r_state;
   assign hb_if.stalled    = r_stalled;
   assign hb_if.recovering = r_recovering;

endmodule

// File: tb/tb_watchdog_heartbeat_gen.sv
// Bench for watchdog_heartbeat_gen: directed test-plan steps then random traffic, compared each cycle against a timing model.
module tb_watchdog_heartbeat_gen;
   localparam int P = 8;
   localparam int W = 20;
   localparam int R = 5;

   logic clk;
   logic rstn;
   watchdog_heartbeat_gen_if hb_if ();

   watchdog_heartbeat_gen #(
      .HB_PERIOD(P), .ALIVE_WINDOW(W), .RECOVER_CYCLES(R), .CNT_W(32)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .hb_if(hb_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Model: state code, cycles since RUN entry, cycles since last alive, low force_reset run in RECOVER
   int          m_st;
   int          m_age;
   int          m_quiet;
   int          m_calm;
   int          m_miss;
   bit          m_prev_inj;
   bit          m_hb;
   logic [15:0] m_cnt;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_age = 0; m_quiet = 0; m_calm = 0; m_miss = 0;
      m_prev_inj = 1'b0; m_hb = 1'b0; m_cnt = 16'd0;
   endtask

   task automatic model_step();
      int nst;
      bit nhb;
      bit inj;
      int len;
`ifdef HB_MISS_INJECT_EN
      inj = hb_if.inject_miss;
      len = int'(hb_if.miss_len);
`else
      inj = 1'b0;
      len = 0;
`endif
      if (m_hb) m_cnt = m_cnt + 16'd1;
      nhb = 1'b0;
      nst = m_st;
      if (!hb_if.enable) begin
         nst = 0; m_miss = 0;
      end else if (hb_if.force_reset) begin
         nst = 3; m_calm = 0; m_miss = 0;
      end else begin
         case (m_st)
            0: begin nst = 1; m_age = 0; m_quiet = 0; end
            1: begin
               if (!hb_if.alive && m_quiet == W - 1) begin
                  nst = 2; m_miss = 0;
               end else begin
                  if ((m_age + 1) % P == 0) begin
                     if (m_miss > 0) m_miss--;
                     else nhb = 1'b1;
                  end
                  if (inj && !m_prev_inj && len != 0) m_miss = len;
                  m_age++;
                  m_quiet = hb_if.alive ? 0 : m_quiet + 1;
               end
            end
            2: if (hb_if.alive) begin nst = 1; m_age = 0; m_quiet = 0; end
            default: begin
               if (m_calm == R - 1) begin nst = 1; m_age = 0; m_quiet = 0; end
               else m_calm++;
            end
         endcase
      end
      m_prev_inj = inj;
      m_hb = nhb;
      m_st = nst;
   endtask

   task automatic check_all();
      chk("heartbeat", {15'd0, hb_if.heartbeat}, {15'd0, m_hb});
      chk("hb_count", hb_if.hb_count, m_cnt);
      chk("state", {14'd0, hb_if.state}, 16'(m_st));
      chk("stalled", {15'd0, hb_if.stalled}, {15'd0, (m_st == 2)});
      chk("recovering", {15'd0, hb_if.recovering}, {15'd0, (m_st == 3)});
`ifdef HB_MISS_INJECT_EN
      chk("inject_active", {15'd0, hb_if.inject_active}, {15'd0, (m_miss != 0)});
`endif
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         if (!rstn) model_reset();
         else model_step();
         @(negedge clk);
         check_all();
      end
   endtask

   // Leaves the bench at the negedge of the first RUN cycle (T).
   task automatic enter_run(input bit alive_v);
      hb_if.force_reset = 1'b0;
      hb_if.alive = alive_v;
      hb_if.enable = 1'b0;
      step(1);
      hb_if.enable = 1'b1;
      step(1);
   endtask

   int hb_seen;
   int alive_pct;
   int fr_left;

   initial begin
      rstn = 1'b0;
      hb_if.enable = 1'b0;
      hb_if.alive = 1'b0;
      hb_if.force_reset = 1'b0;
`ifdef HB_MISS_INJECT_EN
      hb_if.inject_miss = 1'b0;
      hb_if.miss_len = 8'd0;
`endif
      model_reset();
      step(3);
      chk("reset_state", {14'd0, hb_if.state}, 16'd0);
      rstn = 1'b1;

      // Basic run with alive every 4 cycles
      enter_run(1'b1);
      for (int k = 0; k < 25; k++) begin
         hb_if.alive = (k % 4 == 0);
         step(1);
      end
      chk("basic_hb_count_T25", hb_if.hb_count, 16'd3);

      // Stall and resume
      enter_run(1'b0);
      step(20);
      chk("stall_at_T20", {15'd0, hb_if.stalled}, 16'd1);
      step(20);
      hb_if.alive = 1'b1;
      step(1);
      hb_if.alive = 1'b0;
      step(10);

      // Recovery hold-off restarts on a late force_reset
      enter_run(1'b1);
      step(5);
      hb_if.force_reset = 1'b1; step(3);
      hb_if.force_reset = 1'b0; step(4);
      hb_if.force_reset = 1'b1; step(1);
      hb_if.force_reset = 1'b0; step(4);
      chk("recover_hold", {14'd0, hb_if.state}, 16'd3);
      step(1);
      chk("recover_exit", {14'd0, hb_if.state}, 16'd1);

      // Alive in the expiry cycle wins
      enter_run(1'b0);
      step(19);
      hb_if.alive = 1'b1;
      step(1);
      chk("alive_at_expiry", {14'd0, hb_if.state}, 16'd1);
      hb_if.alive = 1'b0;
      step(3);

      // force_reset in the heartbeat-due cycle
      enter_run(1'b1);
      step(7);
      hb_if.force_reset = 1'b1;
      step(1);
      chk("fr_due_no_pulse", {15'd0, hb_if.heartbeat}, 16'd0);
      hb_if.force_reset = 1'b0;
      step(6);

      // Disable from STALL and from RECOVER
      enter_run(1'b0);
      step(22);
      hb_if.enable = 1'b0; step(1);
      chk("stall_disable", {15'd0, hb_if.stalled}, 16'd0);
      hb_if.enable = 1'b1; hb_if.force_reset = 1'b1; step(1);
      hb_if.force_reset = 1'b0; step(2);
      hb_if.enable = 1'b0; step(1);
      chk("recover_disable", {15'd0, hb_if.recovering}, 16'd0);

      // Asynchronous reset mid-RUN
      enter_run(1'b1);
      step(10);
      rstn = 1'b0;
      #1;
      chk("async_rst_count", hb_if.hb_count, 16'd0);
      model_reset();
      step(2);
      rstn = 1'b1;
      step(3);

      // hb_count wrap
      enter_run(1'b1);
      force dut.r_hb_count = 16'hFFFF;
      #1;
      release dut.r_hb_count;
      m_cnt = 16'hFFFF;
      step(9);
      chk("wrap_to_zero", hb_if.hb_count, 16'd0);

`ifdef HB_MISS_INJECT_EN
      enter_run(1'b1);
      hb_if.miss_len = 8'd3;
      hb_if.inject_miss = 1'b1;
      hb_seen = 0;
      for (int k = 0; k < 41; k++) begin
         step(1);
         hb_if.inject_miss = 1'b0;
         hb_seen += int'(hb_if.heartbeat);
      end
      chk("inject_three_missing", 16'(hb_seen), 16'd2);
`endif

      // Randomised traffic
      alive_pct = 50;
      fr_left = 0;
      for (int k = 0; k < 4000; k++) begin
         if (k % 200 == 0) alive_pct = (k % 600 == 0) ? 2 : ((k % 400 == 0) ? 10 : 50);
         hb_if.enable = ($urandom_range(0, 299) != 0);
         hb_if.alive = ($urandom_range(0, 99) < alive_pct);
         if (fr_left == 0 && $urandom_range(0, 149) == 0) fr_left = $urandom_range(1, 4);
         hb_if.force_reset = (fr_left > 0);
         if (fr_left > 0) fr_left--;
`ifdef HB_MISS_INJECT_EN
         hb_if.inject_miss = ($urandom_range(0, 39) == 0);
         hb_if.miss_len = 8'($urandom_range(0, 4));
`endif
         step(1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
